mc_controller: RTL and testbench

Multi-cycle MIPS control unit: the sequential successor to the single-cycle decoder. It drives a shared-memory datapath through FETCH/DECODE/EXEC/MEM/WB states, and waits on a memory handshake with a bounded timeout. It covers the existing instruction set (R-type add/addu/sub/subu/and/or/xor/sll/srl/jr/movz, addi/addiu/ori/lui/lw/sw/beq/bne/bgezal/j/jal), traps illegal opcodes, and counts retired instructions. It sits between the IR/flag outputs of the datapath and the datapath's mux selects and write enables.

---
 rtl/mips_ctrl_pkg.sv | 66 ++++++
 rtl/alu_decode.sv | 37 +++
 rtl/mc_controller.sv | 208 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS controller
// Holds opcode/funct values, the controller state encoding and the
// datapath select encodings driven by mc_controller.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_MOVZ = 6'h0A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_MOVZ = 4'b0111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] EXT_SIGN = 2'b00;
    localparam logic [1:0] EXT_LUI  = 2'b01;
    localparam logic [1:0] EXT_ZERO = 2'b10;

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational opcode/funct to ALU operation decode
// Ports: opcode, funct (in, 6 each); alu_ctr (out, 4) ALU operation;
// legal (out, 1) instruction belongs to the supported set.
module alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctr,
    output logic       legal
);

    always_comb begin
        alu_ctr = ALU_ADD;
        legal   = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU, FN_JR: alu_ctr = ALU_ADD;
                    FN_SUB, FN_SUBU:        alu_ctr = ALU_SUB;
                    FN_AND:                 alu_ctr = ALU_AND;
                    FN_OR:                  alu_ctr = ALU_OR;
                    FN_XOR:                 alu_ctr = ALU_XOR;
                    FN_SLL:                 alu_ctr = ALU_SLL;
                    FN_SRL:                 alu_ctr = ALU_SRL;
                    FN_MOVZ:                alu_ctr = ALU_MOVZ;
                    default:                legal   = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LUI, OP_LW, OP_SW, OP_J, OP_JAL: alu_ctr = ALU_ADD;
            OP_ORI:                                                alu_ctr = ALU_OR;
            OP_BEQ, OP_BNE, OP_REGIMM:                             alu_ctr = ALU_SUB;
            default:                                               legal   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control unit with memory timeout
// Ports: clk, reset (sync, active-high); instr, zero, bge, movz flags and
// mem_ack from the datapath/memory; mem_req/mem_we memory request;
// ir_we/pc_we/reg_we write enables; reg_dst, mem_to_reg, pc_src, alu_src,
// ext_op, alu_ctr datapath selects; state (debug), err (sticky trap),
// instr_cnt (retired instructions, wraps).
module mc_controller
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             bge,
    input  logic             movz,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       pc_src,
    output logic             alu_src,
    output logic [1:0]       ext_op,
    output logic [3:0]       alu_ctr,
    output logic [2:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    // Wide enough to hold TIMEOUT itself; at least one bit when TIMEOUT is 0.
    localparam int TO_W = $clog2(TIMEOUT + 2);

    state_t           state_q, state_d;
    logic [TO_W-1:0]  tcnt_q;
    logic [CNT_W-1:0] cnt_q;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [3:0] dec_alu;
    logic       legal;
    logic       is_r;
    logic       waiting;
    logic       timed_out;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign is_r   = (opcode == OP_RTYPE);

    alu_decode u_alu_decode (
        .opcode  (opcode),
        .funct   (funct),
        .alu_ctr (dec_alu),
        .legal   (legal)
    );

    assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);

    // Fires on the wait cycle that would bring the counter to TIMEOUT;
    // an ack in that same cycle takes precedence in the FSM below.
    assign timed_out = (TIMEOUT != 0) && waiting && !mem_ack &&
                       (tcnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            tcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                tcnt_q <= '0;
            else if (waiting && !mem_ack)
                tcnt_q <= tcnt_q + 1'b1;
            // ERR only leaves through reset, so trap entries never count.
            if (state_q != ST_FETCH && state_d == ST_FETCH)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALU;
        pc_src     = PC_PLUS4;
        alu_src    = 1'b0;
        ext_op     = EXT_SIGN;
        alu_ctr    = ALU_ADD;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (timed_out) begin
                    state_d = ST_ERR;
                end
            end

            ST_DECODE: begin
                if (!legal) begin
                    state_d = ST_ERR;
                end else if (opcode == OP_J || opcode == OP_JAL) begin
                    pc_we   = 1'b1;
                    pc_src  = PC_JUMP;
                    state_d = ST_FETCH;
                    if (opcode == OP_JAL) begin
                        reg_we     = 1'b1;
                        reg_dst    = RD_RA;
                        mem_to_reg = M2R_PC;
                    end
                end else if (is_r && funct == FN_JR) begin
                    pc_we   = 1'b1;
                    pc_src  = PC_RS;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                alu_ctr = dec_alu;
                alu_src = (opcode == OP_ADDI) || (opcode == OP_ADDIU) ||
                          (opcode == OP_ORI)  || (opcode == OP_LUI)   ||
                          (opcode == OP_LW)   || (opcode == OP_SW);
                if (opcode == OP_ORI)
                    ext_op = EXT_ZERO;
                else if (opcode == OP_LUI)
                    ext_op = EXT_LUI;
                case (opcode)
                    OP_BEQ: begin
                        pc_we   = zero;
                        pc_src  = PC_BRANCH;
                        state_d = ST_FETCH;
                    end
                    OP_BNE: begin
                        pc_we   = ~zero;
                        pc_src  = PC_BRANCH;
                        state_d = ST_FETCH;
                    end
                    OP_REGIMM: begin
                        // bgezal: link and branch together when rs >= 0.
                        pc_we      = bge;
                        reg_we     = bge;
                        reg_dst    = RD_RA;
                        mem_to_reg = M2R_PC;
                        pc_src     = PC_BRANCH;
                        state_d    = ST_FETCH;
                    end
                    OP_LW, OP_SW: state_d = ST_MEM;
                    default:      state_d = ST_WB;
                endcase
            end

            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_SW);
                if (mem_ack)
                    state_d = (opcode == OP_SW) ? ST_FETCH : ST_WB;
                else if (timed_out)
                    state_d = ST_ERR;
            end

            ST_WB: begin
                reg_we = 1'b1;
                if (instr == 32'h0)
                    reg_we = 1'b0;
                else if (is_r && funct == FN_MOVZ)
                    reg_we = movz;
                if (is_r)
                    reg_dst = RD_RD;
                if (opcode == OP_LW)
                    mem_to_reg = M2R_MEM;
                state_d = ST_FETCH;
            end

            ST_ERR: state_d = ST_ERR;

            default: state_d = ST_ERR;
        endcase

        // The instruction in flight is abandoned at a reset edge, so nothing
        // it would commit may be written in that cycle.
        if (reset) begin
            mem_we = 1'b0;
            ir_we  = 1'b0;
            pc_we  = 1'b0;
            reg_we = 1'b0;
        end
    end

    assign state     = state_q;
    assign err       = (state_q == ST_ERR);
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard testbench for mc_controller
module tb_mc_controller;

    localparam int SF = 0, SD = 1, SE = 2, SM = 3, SW = 4, SX = 5;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        zero, bge, movz, mem_ack;
    logic        mem_req, mem_we, ir_we, pc_we, reg_we, alu_src, err;
    logic [1:0]  reg_dst, mem_to_reg, pc_src, ext_op;
    logic [3:0]  alu_ctr;
    logic [2:0]  state;
    logic [3:0]  instr_cnt;
    logic [21:0] obs;

    mc_controller #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .zero       (zero),
        .bge        (bge),
        .movz       (movz),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .ext_op     (ext_op),
        .alu_ctr    (alu_ctr),
        .state      (state),
        .err        (err),
        .instr_cnt  (instr_cnt)
    );

    assign obs = {state, mem_req, mem_we, ir_we, pc_we, reg_we, reg_dst,
                  mem_to_reg, pc_src, alu_ctr, alu_src, ext_op, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [21:0] exp_q[$];
    logic [21:0] obs_q[$];
    logic        ack_q[$];
    logic [31:0] ins_q[$];
    int          checks;
    int          errors;
    logic [3:0]  exp_cnt;
    logic [21:0] v_fa, v_fw, v_d, v_err;

    localparam logic [31:0] I_ADD    = 32'h012A4020;
    localparam logic [31:0] I_LW     = 32'h8D280004;
    localparam logic [31:0] I_SW     = 32'hAD280004;
    localparam logic [31:0] I_BEQ    = 32'h112A0003;
    localparam logic [31:0] I_BNE    = 32'h152A0003;
    localparam logic [31:0] I_BGEZAL = 32'h05310003;
    localparam logic [31:0] I_MOVZ   = 32'h012A400A;
    localparam logic [31:0] I_NOP    = 32'h00000000;
    localparam logic [31:0] I_J      = 32'h08000010;
    localparam logic [31:0] I_JAL    = 32'h0C000010;
    localparam logic [31:0] I_JR     = 32'h03E00008;
    localparam logic [31:0] I_ADDI   = 32'h21280005;
    localparam logic [31:0] I_ORI    = 32'h35280005;
    localparam logic [31:0] I_LUI    = 32'h3C080005;
    localparam logic [31:0] I_BADOP  = 32'hFC000000;
    localparam logic [31:0] I_BADFN  = 32'h0000003F;

    // Expected output vector: state, mem_req, mem_we, ir_we, pc_we, reg_we,
    // reg_dst, mem_to_reg, pc_src, alu_ctr, alu_src, ext_op, err.
    function automatic logic [21:0] pk(input int st, input int req, input int we,
                                       input int irw, input int pcw, input int rw,
                                       input int rd, input int m2r, input int pcs,
                                       input int alu, input int asrc, input int ext,
                                       input int e);
        return {3'(st), 1'(req), 1'(we), 1'(irw), 1'(pcw), 1'(rw), 2'(rd),
                2'(m2r), 2'(pcs), 4'(alu), 1'(asrc), 2'(ext), 1'(e)};
    endfunction

    task automatic push(input logic [21:0] e, input logic a, input logic [31:0] ins);
        exp_q.push_back(e);
        ack_q.push_back(a);
        ins_q.push_back(ins);
    endtask

    // Drives one queued cycle at a time and records the DUT outputs mid-cycle.
    task automatic play();
        while (ack_q.size() > 0) begin
            mem_ack = ack_q.pop_front();
            instr   = ins_q.pop_front();
            @(negedge clk);
            obs_q.push_back(obs);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_cnt = 4'd0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        mem_ack = 1'b0;
        instr   = I_ADD;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (obs !== v_fw) begin
            errors++;
            $display("FAIL reset_outputs got %h expected %h", obs, v_fw);
        end
        checks++;
        if (instr_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d expected 0", instr_cnt);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_add();
        logic [21:0] e, o;
        int n = 0;
        do_reset();
        push(v_fa, 1'b1, I_ADD);
        push(v_d, 1'b1, I_ADD);
        push(pk(SE,0,0,0,0,0,0,0,0,0,0,0,0), 1'b1, I_ADD);
        push(pk(SW,0,0,0,0,1,1,0,0,0,0,0,0), 1'b1, I_ADD);
        push(v_fw, 1'b0, I_ADD);
        exp_cnt = exp_cnt + 4'd1;
        play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL add cycle %0d got %h expected %h", n, o, e);
            end
            n++;
        end
        checks++;
        if (instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL add_cnt got %0d expected %0d", instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_lw_waits();
        logic [21:0] e, o;
        int n = 0;
        do_reset();
        push(v_fa, 1'b1, I_LW);
        push(v_d, 1'b1, I_LW);
        push(pk(SE,0,0,0,0,0,0,0,0,0,1,0,0), 1'b1, I_LW);
        for (int i = 0; i < 3; i++) push(pk(SM,1,0,0,0,0,0,0,0,0,0,0,0), 1'b0, I_LW);
        push(pk(SM,1,0,0,0,0,0,0,0,0,0,0,0), 1'b1, I_LW);
        push(pk(SW,0,0,0,0,1,0,1,0,0,0,0,0), 1'b1, I_LW);
        push(v_fw, 1'b0, I_LW);
        exp_cnt = exp_cnt + 4'd1;
        play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL lw cycle %0d got %h expected %h", n, o, e);
            end
            n++;
        end
        checks++;
        if (instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL lw_cnt got %0d expected %0d", instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_branches();
        logic [21:0] e, o;
        int n = 0;
        do_reset();
        zero = 1'b0;
        bge  = 1'b1;
        push(v_fa, 1'b1, I_BEQ);
        push(v_d, 1'b1, I_BEQ);
        push(pk(SE,0,0,0,0,0,0,0,1,1,0,0,0), 1'b1, I_BEQ);
        push(v_fa, 1'b1, I_BNE);
        push(v_d, 1'b1, I_BNE);
        push(pk(SE,0,0,0,1,0,0,0,1,1,0,0,0), 1'b1, I_BNE);
        push(v_fa, 1'b1, I_BGEZAL);
        push(v_d, 1'b1, I_BGEZAL);
        push(pk(SE,0,0,0,1,1,2,2,1,1,0,0,0), 1'b1, I_BGEZAL);
        push(v_fw, 1'b0, I_BGEZAL);
        exp_cnt = exp_cnt + 4'd3;
        play();
        bge = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL branch cycle %0d got %h expected %h", n, o, e);
            end
            n++;
        end
        checks++;
        if (instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL branch_cnt got %0d expected %0d", instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_movz_nop();
        logic [21:0] e, o;
        int n = 0;
        do_reset();
        movz = 1'b0;
        push(v_fa, 1'b1, I_MOVZ);
        push(v_d, 1'b1, I_MOVZ);
        push(pk(SE,0,0,0,0,0,0,0,0,7,0,0,0), 1'b1, I_MOVZ);
        push(pk(SW,0,0,0,0,0,1,0,0,0,0,0,0), 1'b1, I_MOVZ);
        push(v_fa, 1'b1, I_NOP);
        push(v_d, 1'b1, I_NOP);
        push(pk(SE,0,0,0,0,0,0,0,0,5,0,0,0), 1'b1, I_NOP);
        push(pk(SW,0,0,0,0,0,1,0,0,0,0,0,0), 1'b1, I_NOP);
        push(v_fw, 1'b0, I_NOP);
        exp_cnt = exp_cnt + 4'd2;
        play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL movz_nop cycle %0d got %h expected %h", n, o, e);
            end
            n++;
        end
        checks++;
        if (instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL movz_nop_cnt got %0d expected %0d", instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_jumps_imm_sw();
        logic [21:0] e, o;
        int n = 0;
        do_reset();
        push(v_fa, 1'b1, I_J);
        push(pk(SD,0,0,0,1,0,0,0,2,0,0,0,0), 1'b1, I_J);
        push(v_fa, 1'b1, I_JAL);
        push(pk(SD,0,0,0,1,1,2,2,2,0,0,0,0), 1'b1, I_JAL);
        push(v_fa, 1'b1, I_JR);
        push(pk(SD,0,0,0,1,0,0,0,3,0,0,0,0), 1'b1, I_JR);
        push(v_fa, 1'b1, I_ADDI);
        push(v_d, 1'b1, I_ADDI);
        push(pk(SE,0,0,0,0,0,0,0,0,0,1,0,0), 1'b1, I_ADDI);
        push(pk(SW,0,0,0,0,1,0,0,0,0,0,0,0), 1'b1, I_ADDI);
        push(v_fa, 1'b1, I_ORI);
        push(v_d, 1'b1, I_ORI);
        push(pk(SE,0,0,0,0,0,0,0,0,3,1,2,0), 1'b1, I_ORI);
        push(pk(SW,0,0,0,0,1,0,0,0,0,0,0,0), 1'b1, I_ORI);
        push(v_fa, 1'b1, I_LUI);
        push(v_d, 1'b1, I_LUI);
        push(pk(SE,0,0,0,0,0,0,0,0,0,1,1,0), 1'b1, I_LUI);
        push(pk(SW,0,0,0,0,1,0,0,0,0,0,0,0), 1'b1, I_LUI);
        push(v_fa, 1'b1, I_SW);
        push(v_d, 1'b1, I_SW);
        push(pk(SE,0,0,0,0,0,0,0,0,0,1,0,0), 1'b1, I_SW);
        push(pk(SM,1,1,0,0,0,0,0,0,0,0,0,0), 1'b1, I_SW);
        push(v_fw, 1'b0, I_SW);
        exp_cnt = exp_cnt + 4'd7;
        play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL jump_imm_sw cycle %0d got %h expected %h", n, o, e);
            end
            n++;
        end
        checks++;
        if (instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL jump_imm_sw_cnt got %0d expected %0d", instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_timeout();
        logic [21:0] e, o;
        int n = 0;
        do_reset();
        push(v_fa, 1'b1, I_J);
        push(pk(SD,0,0,0,1,0,0,0,2,0,0,0,0), 1'b1, I_J);
        for (int i = 0; i < 4; i++) push(v_fw, 1'b0, I_ADD);
        push(v_err, 1'b1, I_ADD);
        push(v_err, 1'b1, I_ADD);
        exp_cnt = exp_cnt + 4'd1;
        play();
        checks++;
        if (instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL timeout_cnt got %0d expected %0d", instr_cnt, exp_cnt);
        end
        do_reset();
        push(v_fw, 1'b0, I_ADD);
        play();
        // MEM wait that runs out also traps.
        do_reset();
        push(v_fa, 1'b1, I_LW);
        push(v_d, 1'b1, I_LW);
        push(pk(SE,0,0,0,0,0,0,0,0,0,1,0,0), 1'b1, I_LW);
        for (int i = 0; i < 4; i++) push(pk(SM,1,0,0,0,0,0,0,0,0,0,0,0), 1'b0, I_LW);
        push(v_err, 1'b0, I_LW);
        play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL timeout cycle %0d got %h expected %h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_illegal();
        logic [21:0] e, o;
        int n = 0;
        do_reset();
        push(v_fa, 1'b1, I_BADOP);
        push(v_d, 1'b1, I_BADOP);
        push(v_err, 1'b1, I_BADOP);
        play();
        checks++;
        if (instr_cnt !== 4'd0) begin
            errors++;
            $display("FAIL illegal_cnt got %0d expected 0", instr_cnt);
        end
        do_reset();
        push(v_fa, 1'b1, I_BADFN);
        push(v_d, 1'b1, I_BADFN);
        push(v_err, 1'b1, I_BADFN);
        play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL illegal cycle %0d got %h expected %h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_sw();
        logic [21:0] e, o;
        int n = 0;
        do_reset();
        push(v_fa, 1'b1, I_J);
        push(pk(SD,0,0,0,1,0,0,0,2,0,0,0,0), 1'b1, I_J);
        push(v_fa, 1'b1, I_SW);
        push(v_d, 1'b1, I_SW);
        push(pk(SE,0,0,0,0,0,0,0,0,0,1,0,0), 1'b1, I_SW);
        push(pk(SM,1,1,0,0,0,0,0,0,0,0,0,0), 1'b0, I_SW);
        push(pk(SM,1,1,0,0,0,0,0,0,0,0,0,0), 1'b0, I_SW);
        exp_cnt = exp_cnt + 4'd1;
        play();
        checks++;
        if (instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL mid_sw_cnt_before got %0d expected %0d", instr_cnt, exp_cnt);
        end
        // Still in MEM with the store pending: reset abandons it.
        reset   = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (obs !== v_fw) begin
            errors++;
            $display("FAIL mid_sw_reset got %h expected %h", obs, v_fw);
        end
        checks++;
        if (instr_cnt !== 4'd0) begin
            errors++;
            $display("FAIL mid_sw_cnt got %0d expected 0", instr_cnt);
        end
        reset   = 1'b0;
        exp_cnt = 4'd0;
        @(posedge clk);
        #1;
        push(v_fw, 1'b0, I_SW);
        play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mid_sw cycle %0d got %h expected %h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            push(v_fa, 1'b1, I_J);
            push(pk(SD,0,0,0,1,0,0,0,2,0,0,0,0), 1'b1, I_J);
            exp_cnt = exp_cnt + 4'd1;
        end
        play();
        obs_q.delete();
        exp_q.delete();
        checks++;
        if (instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL wrap_cnt_15 got %0d expected %0d", instr_cnt, exp_cnt);
        end
        push(v_fa, 1'b1, I_J);
        push(pk(SD,0,0,0,1,0,0,0,2,0,0,0,0), 1'b1, I_J);
        exp_cnt = exp_cnt + 4'd1;
        play();
        obs_q.delete();
        exp_q.delete();
        checks++;
        if (instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL wrap_cnt_16 got %0d expected %0d", instr_cnt, exp_cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 4'd0;
        reset   = 1'b1;
        instr   = 32'h0;
        zero    = 1'b0;
        bge     = 1'b0;
        movz    = 1'b0;
        mem_ack = 1'b0;
        v_fa  = pk(SF,1,0,1,1,0,0,0,0,0,0,0,0);
        v_fw  = pk(SF,1,0,0,0,0,0,0,0,0,0,0,0);
        v_d   = pk(SD,0,0,0,0,0,0,0,0,0,0,0,0);
        v_err = pk(SX,0,0,0,0,0,0,0,0,0,0,0,1);

        test_reset();
        test_add();
        test_lw_waits();
        test_branches();
        test_movz_nop();
        test_jumps_imm_sw();
        test_timeout();
        test_illegal();
        test_reset_mid_sw();
        test_cnt_wrap();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
